// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register read with write-back bypass, immediate and
// control generation, load-use hazard detection, and the ID/EX pipeline register.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_d,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        stall_d,
    output logic        valid_e,
    output logic        regwrite_e,
    output logic        memread_e,
    output logic        memwrite_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        illegal_e,
    output logic [31:0] pc_e,
    output logic [31:0] instr_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e
);

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    imm_fmt_e    immFmt;
    logic [31:0] imm;
    logic        decRegwrite, decMemread, decMemwrite, decBranch, decJump, decIllegal;
    logic        useRs1, useRs2;
    logic [31:0] rd1Byp, rd2Byp;
    logic        lu;
    idex_t       bubble;
    idex_t       idex_q, idex_d;

    assign opcode = instr_d[6:0];
    assign rd     = instr_d[11:7];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    // Unknown opcodes keep rs1 marked as used; a spurious load-use stall on an illegal
    // instruction is harmless.
    always_comb begin
        immFmt      = IMM_NONE;
        decRegwrite = 1'b0;
        decMemread  = 1'b0;
        decMemwrite = 1'b0;
        decBranch   = 1'b0;
        decJump     = 1'b0;
        decIllegal  = 1'b0;
        useRs1      = 1'b1;
        useRs2      = 1'b0;
        case (opcode)
            7'b0110011: begin
                decRegwrite = 1'b1;
                useRs2      = 1'b1;
            end
            7'b0010011: begin
                immFmt      = IMM_I;
                decRegwrite = 1'b1;
            end
            7'b0000011: begin
                immFmt      = IMM_I;
                decRegwrite = 1'b1;
                decMemread  = 1'b1;
            end
            7'b1100111: begin
                immFmt      = IMM_I;
                decRegwrite = 1'b1;
                decJump     = 1'b1;
            end
            7'b0100011: begin
                immFmt      = IMM_S;
                decMemwrite = 1'b1;
                useRs2      = 1'b1;
            end
            7'b1100011: begin
                immFmt      = IMM_B;
                decBranch   = 1'b1;
                useRs2      = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                immFmt      = IMM_U;
                decRegwrite = 1'b1;
                useRs1      = 1'b0;
            end
            7'b1101111: begin
                immFmt      = IMM_J;
                decRegwrite = 1'b1;
                decJump     = 1'b1;
                useRs1      = 1'b0;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = 32'h0;
        case (immFmt)
            IMM_I:   imm = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   imm = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25],
                            instr_d[11:8], 1'b0};
            IMM_U:   imm = {instr_d[31:12], 12'h000};
            IMM_J:   imm = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20],
                            instr_d[30:21], 1'b0};
            default: imm = 32'h0;
        endcase
    end

    // The register file writes at the same edge ID/EX captures, so a same-cycle
    // write-back must be forwarded here.
    assign rd1Byp = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_rd1;
    assign rd2Byp = (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_rd2;

    assign lu = idex_q.valid && idex_q.memread && (idex_q.rd != 5'd0) && valid_d &&
                ((useRs1 && (idex_q.rd == rs1)) || (useRs2 && (idex_q.rd == rs2)));

    assign stall_d = lu | stall_e;

    always_comb begin
        bubble       = '0;
        bubble.instr = NOP_INSTR;
    end

    // Flush beats stall; a load-use or empty IF/ID inserts a bubble.
    always_comb begin
        idex_d = idex_q;
        if (flush_e) begin
            idex_d = bubble;
        end else if (stall_e) begin
            idex_d = idex_q;
        end else if (lu || !valid_d) begin
            idex_d = bubble;
        end else begin
            idex_d.valid    = 1'b1;
            idex_d.regwrite = decRegwrite && (rd != 5'd0);
            idex_d.memread  = decMemread;
            idex_d.memwrite = decMemwrite;
            idex_d.branch   = decBranch;
            idex_d.jump     = decJump;
            idex_d.illegal  = decIllegal;
            idex_d.pc       = pc_d;
            idex_d.instr    = instr_d;
            idex_d.rd1      = rd1Byp;
            idex_d.rd2      = rd2Byp;
            idex_d.imm      = imm;
            idex_d.rs1      = useRs1 ? rs1 : 5'd0;
            idex_d.rs2      = useRs2 ? rs2 : 5'd0;
            idex_d.rd       = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign valid_e    = idex_q.valid;
    assign regwrite_e = idex_q.regwrite;
    assign memread_e  = idex_q.memread;
    assign memwrite_e = idex_q.memwrite;
    assign branch_e   = idex_q.branch;
    assign jump_e     = idex_q.jump;
    assign illegal_e  = idex_q.illegal;
    assign pc_e       = idex_q.pc;
    assign instr_e    = idex_q.instr;
    assign rd1_e      = idex_q.rd1;
    assign rd2_e      = idex_q.rd2;
    assign imm_e      = idex_q.imm;
    assign rs1_e      = idex_q.rs1;
    assign rs2_e      = idex_q.rs2;
    assign rd_e       = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each step pushes its expected ID/EX contents to a
// scoreboard queue, which is popped and compared one cycle later.
module tb_decode_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI     = 32'hFFF0_8293;
    localparam logic [31:0] ADDI_X0  = 32'h0010_8013;
    localparam logic [31:0] ADD3     = 32'h0020_81B3;
    localparam logic [31:0] LW4      = 32'h0001_2203;
    localparam logic [31:0] ADD6     = 32'h0012_0333;
    localparam logic [31:0] LUI4     = 32'h0000_1237;
    localparam logic [31:0] BEQ      = 32'h0020_8063;
    localparam logic [31:0] SW_ALL   = 32'hFE20_AFA3;
    localparam logic [31:0] BEQ_ALL  = 32'hFE20_8FE3;
    localparam logic [31:0] JAL_ALL  = 32'hFFFF_F0EF;
    localparam logic [31:0] LUI_ALL  = 32'hFFFF_F3B7;
    localparam logic [31:0] ILL      = 32'h0000_007F;

    // Control order: valid, regwrite, memread, memwrite, branch, jump, illegal
    localparam logic [6:0] C_BUB   = 7'b0000000;
    localparam logic [6:0] C_ALU   = 7'b1100000;
    localparam logic [6:0] C_NORW  = 7'b1000000;
    localparam logic [6:0] C_LOAD  = 7'b1110000;
    localparam logic [6:0] C_STORE = 7'b1001000;
    localparam logic [6:0] C_BR    = 7'b1000100;
    localparam logic [6:0] C_JAL   = 7'b1100010;
    localparam logic [6:0] C_ILL   = 7'b1000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d;
    logic [31:0] instr_d, pc_d;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_e, flush_e, stall_d;
    logic        valid_e, regwrite_e, memread_e, memwrite_e, branch_e, jump_e, illegal_e;
    logic [31:0] pc_e, instr_e, rd1_e, rd2_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sbQ[$];
    exp_t heldExp;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_e(stall_e), .flush_e(flush_e), .stall_d(stall_d),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .memwrite_e(memwrite_e), .branch_e(branch_e), .jump_e(jump_e),
        .illegal_e(illegal_e), .pc_e(pc_e), .instr_e(instr_e), .rd1_e(rd1_e),
        .rd2_e(rd2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
    );

    function automatic exp_t mk(string tag, logic [6:0] ctrl, logic [31:0] pc,
                                logic [31:0] instr, logic [31:0] rd1, logic [31:0] rd2,
                                logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.pc = pc; e.instr = instr; e.rd1 = rd1;
        e.rd2 = rd2; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        return e;
    endfunction

    function automatic exp_t bub(string tag);
        return mk(tag, C_BUB, 32'h0, NOP, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    endfunction

    task automatic cmp(string tag, logic [31:0] observed, logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(logic v, logic [31:0] instr, logic [31:0] pc,
                                 logic [31:0] r1, logic [31:0] r2);
        valid_d     = v;
        instr_d     = instr;
        pc_d        = pc;
        rf_rd1      = r1;
        rf_rd2      = r2;
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
        stall_e     = 1'b0;
        flush_e     = 1'b0;
    endtask

    task automatic checkStall(string tag, logic expected);
        #1;
        cmp(tag, {31'd0, stall_d}, {31'd0, expected});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        total++;
        assert (sbQ.size() > 0) else begin
            bad++;
            $error("[TB] FAIL sb_pop observed=empty expected=entry");
        end
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            cmp({e.tag, ".ctrl"}, {25'd0, valid_e, regwrite_e, memread_e, memwrite_e,
                                    branch_e, jump_e, illegal_e}, {25'd0, e.ctrl});
            cmp({e.tag, ".pc"}, pc_e, e.pc);
            cmp({e.tag, ".instr"}, instr_e, e.instr);
            cmp({e.tag, ".rd1"}, rd1_e, e.rd1);
            cmp({e.tag, ".rd2"}, rd2_e, e.rd2);
            cmp({e.tag, ".imm"}, imm_e, e.imm);
            cmp({e.tag, ".idx"}, {17'd0, rs1_e, rs2_e, rd_e}, {17'd0, e.rs1, e.rs2, e.rd});
        end
    endtask

    initial begin
        $display("[TB] decode_stage directed test start");
        rst = 1'b1;
        applyStimulus(1'b1, ADDI, 32'h40, 32'd10, 32'd0);
        sbQ.push_back(bub("rst1")); tick(); checkOutput();
        sbQ.push_back(bub("rst2")); tick(); checkOutput();
        rst = 1'b0;
        checkStall("rst_stall_d", 1'b0);

        applyStimulus(1'b1, ADDI, 32'h100, 32'd10, 32'd0);
        sbQ.push_back(mk("addi", C_ALU, 32'h100, ADDI, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd5));
        tick(); checkOutput();

        applyStimulus(1'b1, ADDI_X0, 32'h104, 32'd3, 32'd0);
        sbQ.push_back(mk("addi_x0", C_NORW, 32'h104, ADDI_X0, 32'd3, 32'd0, 32'd1, 5'd1, 5'd0, 5'd0));
        tick(); checkOutput();

        applyStimulus(1'b1, ADD3, 32'h108, 32'd1, 32'd2);
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD;
        sbQ.push_back(mk("byp_rs1", C_ALU, 32'h108, ADD3, 32'hDEAD, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3));
        tick(); checkOutput();

        applyStimulus(1'b1, ADD3, 32'h10C, 32'd1, 32'd2);
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        sbQ.push_back(mk("byp_x0", C_ALU, 32'h10C, ADD3, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3));
        tick(); checkOutput();

        applyStimulus(1'b1, ADD3, 32'h110, 32'd1, 32'd2);
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'hBEEF;
        sbQ.push_back(mk("byp_rs2", C_ALU, 32'h110, ADD3, 32'd1, 32'hBEEF, 32'd0, 5'd1, 5'd2, 5'd3));
        tick(); checkOutput();

        applyStimulus(1'b1, ADD3, 32'h114, 32'd1, 32'd2);
        wb_regwrite = 1'b0; wb_rd = 5'd1; wb_data = 32'hDEAD;
        sbQ.push_back(mk("byp_norw", C_ALU, 32'h114, ADD3, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3));
        tick(); checkOutput();

        applyStimulus(1'b1, LW4, 32'h200, 32'd100, 32'd0);
        sbQ.push_back(mk("lw", C_LOAD, 32'h200, LW4, 32'd100, 32'd0, 32'd0, 5'd2, 5'd0, 5'd4));
        tick(); checkOutput();

        applyStimulus(1'b1, ADD6, 32'h204, 32'd7, 32'd8);
        checkStall("lu_stall", 1'b1);
        sbQ.push_back(bub("lu_bubble")); tick(); checkOutput();
        checkStall("lu_release", 1'b0);
        sbQ.push_back(mk("lu_add", C_ALU, 32'h204, ADD6, 32'd7, 32'd8, 32'd0, 5'd4, 5'd1, 5'd6));
        tick(); checkOutput();

        applyStimulus(1'b1, LUI4, 32'h208, 32'd0, 32'd0);
        sbQ.push_back(mk("lui_x4", C_ALU, 32'h208, LUI4, 32'd0, 32'd0, 32'h1000, 5'd0, 5'd0, 5'd4));
        tick(); checkOutput();
        applyStimulus(1'b1, ADD6, 32'h20C, 32'd7, 32'd8);
        checkStall("lui_nostall", 1'b0);
        sbQ.push_back(mk("add_after_lui", C_ALU, 32'h20C, ADD6, 32'd7, 32'd8, 32'd0, 5'd4, 5'd1, 5'd6));
        tick(); checkOutput();

        applyStimulus(1'b0, ADD6, 32'h210, 32'd7, 32'd8);
        sbQ.push_back(bub("invalid_d")); tick(); checkOutput();

        applyStimulus(1'b1, BEQ, 32'h300, 32'd5, 32'd6);
        heldExp = mk("beq", C_BR, 32'h300, BEQ, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd0);
        sbQ.push_back(heldExp); tick(); checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ADDI, 32'h304, 32'd9, 32'd9);
            stall_e = 1'b1;
            checkStall("stall_e_sd", 1'b1);
            heldExp.tag = $sformatf("hold%0d", i);
            sbQ.push_back(heldExp); tick(); checkOutput();
        end
        applyStimulus(1'b1, ADDI, 32'h304, 32'd9, 32'd9);
        sbQ.push_back(mk("addi_release", C_ALU, 32'h304, ADDI, 32'd9, 32'd9, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd5));
        tick(); checkOutput();

        applyStimulus(1'b1, BEQ, 32'h308, 32'd5, 32'd6);
        heldExp = mk("beq2", C_BR, 32'h308, BEQ, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd0);
        sbQ.push_back(heldExp); tick(); checkOutput();
        applyStimulus(1'b1, ADDI, 32'h30C, 32'd9, 32'd9);
        stall_e = 1'b1;
        heldExp.tag = "hold_pre_flush";
        sbQ.push_back(heldExp); tick(); checkOutput();
        stall_e = 1'b1; flush_e = 1'b1;
        checkStall("flush_sd", 1'b1);
        sbQ.push_back(bub("flush_bubble")); tick(); checkOutput();
        flush_e = 1'b0;
        sbQ.push_back(bub("hold_bubble")); tick(); checkOutput();

        applyStimulus(1'b1, ADDI, 32'h400, 32'd10, 32'd0);
        sbQ.push_back(mk("addi_pre_rst", C_ALU, 32'h400, ADDI, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd5));
        tick(); checkOutput();
        stall_e = 1'b1; rst = 1'b1;
        sbQ.push_back(bub("rst_mid_stall")); tick(); checkOutput();
        checkStall("rst_stall_e_sd", 1'b1);
        rst = 1'b0; stall_e = 1'b0;
        checkStall("post_rst_sd", 1'b0);

        applyStimulus(1'b1, SW_ALL, 32'h500, 32'd3, 32'd4);
        sbQ.push_back(mk("sw_imm", C_STORE, 32'h500, SW_ALL, 32'd3, 32'd4, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd31));
        tick(); checkOutput();
        applyStimulus(1'b1, BEQ_ALL, 32'h504, 32'd3, 32'd4);
        sbQ.push_back(mk("beq_imm", C_BR, 32'h504, BEQ_ALL, 32'd3, 32'd4, 32'hFFFF_FFFE, 5'd1, 5'd2, 5'd31));
        tick(); checkOutput();
        applyStimulus(1'b1, JAL_ALL, 32'h508, 32'd3, 32'd4);
        sbQ.push_back(mk("jal_imm", C_JAL, 32'h508, JAL_ALL, 32'd3, 32'd4, 32'hFFFF_FFFE, 5'd0, 5'd0, 5'd1));
        tick(); checkOutput();
        applyStimulus(1'b1, LUI_ALL, 32'h50C, 32'd3, 32'd4);
        sbQ.push_back(mk("lui_imm", C_ALU, 32'h50C, LUI_ALL, 32'd3, 32'd4, 32'hFFFF_F000, 5'd0, 5'd0, 5'd7));
        tick(); checkOutput();
        applyStimulus(1'b1, ILL, 32'h510, 32'd0, 32'd0);
        sbQ.push_back(mk("illegal", C_ILL, 32'h510, ILL, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
        tick(); checkOutput();
        applyStimulus(1'b0, ILL, 32'h514, 32'd0, 32'd0);
        sbQ.push_back(bub("illegal_invalid")); tick(); checkOutput();

        cmp("sb_empty", sbQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage RV32I pipeline, sitting between the IF/ID register and the execute stage. It drives the register-file read addresses from the fetched instruction and applies write-back bypass to the returned read data. It generates the immediate and main control signals, detects load-use hazards, and holds the resulting ID/EX pipeline register with stall and flush control.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: encoding reported in `instr_e` for bubbles.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_d` in 1: IF/ID holds a real instruction.
- `instr_d` in 32: instruction from IF/ID.
- `pc_d` in 32: PC of `instr_d`.
- `rf_a1`, `rf_a2` out 5: register-file read addresses; combinational `instr_d[19:15]`, `instr_d[24:20]`.
- `rf_rd1`, `rf_rd2` in 32: register-file read data; asynchronous, x0 reads 0.
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_data` in 32: write-back port, the same values presented to the register file this cycle.
- `stall_e` in 1: execute cannot accept; hold ID/EX.
- `flush_e` in 1: branch/jump redirect; kill the instruction entering ID/EX.
- `stall_d` out 1: combinational; IF/ID must hold.
- `valid_e`, `regwrite_e`, `memread_e`, `memwrite_e`, `branch_e`, `jump_e`, `illegal_e` out 1: registered controls.
- `pc_e`, `instr_e`, `rd1_e`, `rd2_e`, `imm_e` out 32: registered datapath fields.
- `rs1_e`, `rs2_e`, `rd_e` out 5: registered register indices for forwarding.

## Operation
- Opcode decode of `instr_d[6:0]`, giving immediate format and control signals:
  - OP 0110011: no immediate (0); regwrite.
  - OP-IMM 0010011: I-type; regwrite.
  - LOAD 0000011: I-type; regwrite, memread.
  - JALR 1100111: I-type; regwrite, jump.
  - STORE 0100011: S-type; memwrite.
  - BRANCH 1100011: B-type; branch.
  - LUI 0110111 and AUIPC 0010111: U-type; regwrite.
  - JAL 1101111: J-type; regwrite, jump.
  - Any other opcode: `illegal_e`=1, all other controls 0, `imm_e`=0.
- Immediates are sign-extended from bit 31. B and J immediates have bit 0 = 0. U immediate = `{instr[31:12],12'b0}`.
- `regwrite_e` is forced to 0 when rd = 0.
- Register usage:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH.
  - `rs1_e`/`rs2_e` are written as 0 when the register is unused.
- Write-back bypass: if `wb_regwrite` && `wb_rd`≠0 && `wb_rd`==rs1, then `wb_data` replaces `rf_rd1`. The same rule applies to rs2 and `rf_rd2`.
- Load-use hazard, `lu`: `valid_e` && `memread_e` && `rd_e`≠0 && `valid_d` && `rd_e` matches a used rs1/rs2 of `instr_d`.
- `stall_d` = `lu` | `stall_e`.
- ID/EX update, priority highest first:
  1. `rst`: all outputs 0, except `instr_e`=`NOP_INSTR`.
  2. `flush_e`: load a bubble.
  3. `stall_e`: hold all fields unchanged.
  4. `lu`: load a bubble.
  5. Otherwise: capture the decoded instruction. `valid_e`=`valid_d`; if `valid_d`=0, load a bubble.
- Bubble contents: `valid_e` and all controls 0, `illegal_e`=0, `instr_e`=`NOP_INSTR`. Data fields `pc_e`, `rd1_e`, `rd2_e`, `imm_e` are 0; `rs1_e`, `rs2_e`, `rd_e` are 0.
- `illegal_e` is only set when the captured instruction has `valid_d`=1.

## Timing
- Decode-to-ID/EX latency: 1 cycle. An instruction present in IF/ID at edge N appears on the `_e` outputs after edge N.
- `rf_a1`, `rf_a2`, `stall_d` and the bypass are purely combinational in cycle N.
- The register file writes at the same edge at which ID/EX captures. The bypass is therefore mandatory for a same-cycle WB→ID dependency.
- Load-use costs exactly one bubble:
  - Cycle N: `stall_d`=1 and the bubble is captured.
  - Cycle N+1: the load has left ID/EX (`memread_e`=0), so `lu` deasserts and the held instruction is captured.
- `flush_e` together with `lu` or `stall_e`: the flush wins and a bubble is captured. `stall_d` still reflects `lu`|`stall_e`; IF/ID redirect is resolved upstream.
- Reset asserted mid-stall clears ID/EX in the same edge. `stall_d` is 0 after reset, unless `stall_e` is asserted.

## Test plan
- Reset: assert `rst` for 2 cycles with `valid_d`=1 → after the edge, `valid_e`=0, all controls 0, `instr_e`=`32'h00000013`.
- `addi x5,x1,-1` (`32'hFFF08293`), with `rf_rd1`=10 → next cycle: `imm_e`=`32'hFFFFFFFF`, `rd_e`=5, `regwrite_e`=1, `rd1_e`=10.
- Bypass: `add x3,x1,x2` with `rf_rd1`=1, `wb_regwrite`=1, `wb_rd`=1, `wb_data`=`32'hDEAD` → `rd1_e`=`32'hDEAD`. Repeat with `wb_rd`=0 → `rd1_e`=1.
- Load-use: `lw x4,0(x2)` followed by `add x6,x4,x1` →
  - Cycle 2: `stall_d`=1, and ID/EX holds a bubble.
  - Cycle 3: the add is captured, with `stall_d`=0.
  - Substituting `lui x4` for the load → no stall.
- `stall_e`=1 for 3 cycles with a valid `beq` in ID/EX → all `_e` outputs stay unchanged. `flush_e`=1 on the 2nd of those cycles → bubble next cycle.
- Immediate formats: `sw`, `beq`, `jal`, `lui` with all immediate bits set → `imm_e`=−1, −2, −2 and `32'hFFFFF000` respectively. Opcode `1111111` → `illegal_e`=1.
